// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue: issues iram reads ahead of decode into a small
// (pc, instruction) FIFO, with branch redirect/flush and a sticky fetch fault.
module inst_prefetch_buf #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    output logic                       iram_rd_req_o,
    output logic [XLEN-1:0]            iram_rd_addr_o,
    input  logic [XLEN-1:0]            iram_rd_data_i,
    input  logic                       redirect_en_i,
    input  logic [XLEN-1:0]            redirect_addr_i,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    output logic [XLEN-1:0]            inst_data_o,
    output logic [XLEN-1:0]            inst_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] fill_level_o,
    output logic                       cpu_fault_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    function automatic logic is_bad_inst(input logic [XLEN-1:0] inst);
        return (inst[15:0] == 16'h0000) || (&inst);
    endfunction

    logic [XLEN-1:0]  pc_mem_q   [DEPTH];
    logic [XLEN-1:0]  pc_mem_d   [DEPTH];
    logic [XLEN-1:0]  data_mem_q [DEPTH];
    logic [XLEN-1:0]  data_mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_addr_q, inflight_addr_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             fault_q, fault_d;

    logic             head_valid_s;
    logic             req_s;
    logic [XLEN-1:0]  addr_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W:0]   occ_s;

    // A redirect in the same cycle hides the head so decode cannot consume a flushed entry.
    assign head_valid_s = (count_q != {CNT_W{1'b0}}) && !fault_q && !redirect_en_i;

    // Next-state: fault freezes everything, redirect flushes, otherwise push/pop/issue.
    always_comb begin
        pc_mem_d        = pc_mem_q;
        data_mem_d      = data_mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        inflight_d      = inflight_q;
        inflight_addr_d = inflight_addr_q;
        fetch_pc_d      = fetch_pc_q;
        fault_d         = fault_q;
        req_s           = 1'b0;
        addr_s          = fetch_pc_q;
        push_s          = 1'b0;
        pop_s           = 1'b0;
        occ_s           = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

        if (fault_q) begin
            inflight_d = 1'b0;
        end else if (redirect_en_i) begin
            // The response arriving this cycle belongs to the old stream and is dropped.
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            addr_s   = redirect_addr_i;
            if (redirect_addr_i[1:0] != 2'b00) begin
                fault_d    = 1'b1;
                inflight_d = 1'b0;
            end else begin
                req_s           = 1'b1;
                fetch_pc_d      = redirect_addr_i + XLEN'(3'd4);
                inflight_d      = 1'b1;
                inflight_addr_d = redirect_addr_i;
            end
        end else begin
            push_s = inflight_q;
            pop_s  = head_valid_s && inst_ready_i;
            // Occupancy ignores a same-cycle pop so a full queue never overflows.
            req_s  = occ_s < (CNT_W+1)'(DEPTH);

            if (push_s) begin
                pc_mem_d[wr_ptr_q]   = inflight_addr_q;
                data_mem_d[wr_ptr_q] = iram_rd_data_i;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
                fault_d  = is_bad_inst(data_mem_q[rd_ptr_q]);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase

            if (req_s) begin
                fetch_pc_d      = fetch_pc_q + XLEN'(3'd4);
                inflight_addr_d = fetch_pc_q;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            inflight_d = req_s;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= {XLEN{1'b0}};
                data_mem_q[i] <= {XLEN{1'b0}};
            end
            wr_ptr_q        <= {PTR_W{1'b0}};
            rd_ptr_q        <= {PTR_W{1'b0}};
            count_q         <= {CNT_W{1'b0}};
            inflight_q      <= 1'b0;
            inflight_addr_q <= {XLEN{1'b0}};
            fetch_pc_q      <= RESET_PC;
            fault_q         <= 1'b0;
        end else begin
            pc_mem_q        <= pc_mem_d;
            data_mem_q      <= data_mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            fetch_pc_q      <= fetch_pc_d;
            fault_q         <= fault_d;
        end
    end

    // Gating with rst_n_i keeps the request low while reset is held.
    assign iram_rd_req_o  = req_s && rst_n_i;
    assign iram_rd_addr_o = rst_n_i ? addr_s : fetch_pc_q;
    assign inst_valid_o   = head_valid_s;
    assign inst_data_o    = head_valid_s ? data_mem_q[rd_ptr_q] : NOP_INST;
    assign inst_pc_o      = head_valid_s ? pc_mem_q[rd_ptr_q] : {XLEN{1'b0}};
    assign fill_level_o   = count_q;
    assign cpu_fault_o    = fault_q;

endmodule
